// File: rtl/cardinal_nic.sv
`default_nettype none
// ============================================================================
// Module   : cardinal_nic
// Purpose  : Network interface controller for one node of the cardinal-router
//            mesh. Couples a processor register interface to the router's
//            local port with a single-entry buffer in each direction.
//            Injection is gated so a flit only leaves in a cycle whose
//            router polarity matches the flit's VC bit (bit 63).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-low reset
//   addr         in   register select (0 ib data, 1 ib status,
//                                      2 ob data, 3 ob status)
//   d_in         in   processor write data
//   d_out        out  processor read data (registered)
//   nicEn        in   register access enable
//   nicWrEn      in   1 = write, 0 = read
//   net_so       out  flit valid toward router
//   net_ro       in   router ready for injected flit
//   net_do       out  flit toward router
//   net_polarity in   router polarity
//   net_si       in   flit valid from router
//   net_ri       out  ready toward router
//   net_di       in   flit from router
// Flit: [63] VC, [62] Xdir, [61] Ydir, [60:56] rsvd, [55:52] hopX,
//       [51:48] hopY, [47:0] payload. Passed through unmodified.
// ============================================================================
module cardinal_nic #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    output logic              net_so,
    input  logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_polarity,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [DATA_W-1:0] net_di
);

    localparam logic [ADDR_W-1:0] ADDR_IB_DATA = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_IB_STAT = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_OB_DATA = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_OB_STAT = ADDR_W'(3);

    logic [DATA_W-1:0] ob_data_q, ob_data_d;
    logic              ob_full_q, ob_full_d;
    logic [DATA_W-1:0] ib_data_q, ib_data_d;
    logic              ib_full_q, ib_full_d;
    logic [DATA_W-1:0] d_out_q,   d_out_d;

    logic wr_access;
    logic rd_access;
    logic ob_load;
    logic ib_capture;
    logic ib_drain;

    // ------------------------------------------------------------------
    // Router-facing combinational outputs
    // ------------------------------------------------------------------
    assign net_do = ob_data_q;
    assign net_so = ob_full_q & net_ro & (net_polarity == ob_data_q[DATA_W-1]);
    assign net_ri = ~ib_full_q;
    assign d_out  = d_out_q;

    assign wr_access  = nicEn & nicWrEn;
    assign rd_access  = nicEn & ~nicWrEn;

    // A write is judged on the pre-edge ob_full, so a write landing in the
    // same cycle as a send is still dropped.
    assign ob_load    = wr_access & (addr == ADDR_OB_DATA) & ~ob_full_q;
    assign ib_capture = net_si & ~ib_full_q;
    assign ib_drain   = rd_access & (addr == ADDR_IB_DATA);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ob_data_d = ob_data_q;
        ob_full_d = ob_full_q;
        ib_data_d = ib_data_q;
        ib_full_d = ib_full_q;
        d_out_d   = d_out_q;

        // Output buffer: a send only happens when full and a load only when
        // empty, so the two never collide.
        if (net_so) begin
            ob_full_d = 1'b0;
        end
        if (ob_load) begin
            ob_data_d = d_in;
            ob_full_d = 1'b1;
        end

        // Input buffer: capture takes priority over a drain so that a flit
        // arriving while an empty buffer is being read is kept.
        if (ib_drain) begin
            ib_full_d = 1'b0;
        end
        if (ib_capture) begin
            ib_data_d = net_di;
            ib_full_d = 1'b1;
        end

        // Read data returns the pre-edge register contents.
        if (rd_access) begin
            case (addr)
                ADDR_IB_DATA: d_out_d = ib_data_q;
                ADDR_IB_STAT: d_out_d = {{(DATA_W-1){1'b0}}, ib_full_q};
                ADDR_OB_DATA: d_out_d = ob_data_q;
                ADDR_OB_STAT: d_out_d = {{(DATA_W-1){1'b0}}, ob_full_q};
                default:      d_out_d = d_out_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            ob_data_q <= '0;
            ob_full_q <= 1'b0;
            ib_data_q <= '0;
            ib_full_q <= 1'b0;
            d_out_q   <= '0;
        end else begin
            ob_data_q <= ob_data_d;
            ob_full_q <= ob_full_d;
            ib_data_q <= ib_data_d;
            ib_full_q <= ib_full_d;
            d_out_q   <= d_out_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cardinal_nic.sv
`default_nettype none
// ============================================================================
// Module   : tb_cardinal_nic
// Purpose  : Directed self-checking bench for cardinal_nic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cardinal_nic;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;

    int checks;
    int errors;

    cardinal_nic #(.DATA_W(64), .ADDR_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [63:0] d);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        tick();
        nicEn = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (4) tick();
        #1;
        checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL reset_net_so got %0b exp 0", net_so); end
        checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL reset_net_ri got %0b exp 1", net_ri); end
        checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL reset_d_out got %h exp 0", d_out); end
        reset = 1'b1;
        cpu_read(2'd1);
        checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL reset_ib_stat got %h exp 0", d_out); end
        cpu_read(2'd3);
        checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL reset_ob_stat got %h exp 0", d_out); end
    endtask

    task automatic test_polarity();
        net_ro = 1'b1; net_polarity = 1'b0;
        cpu_write(2'd2, 64'hA000_0000_0000_1234);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL pol_wait_so[%0d] got %0b exp 0", i, net_so); end
            tick();
        end
        net_polarity = 1'b1;
        #1;
        checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL pol_send_so got %0b exp 1", net_so); end
        checks++; if (net_do !== 64'hA000_0000_0000_1234) begin errors++; $display("FAIL pol_send_do got %h exp a000000000001234", net_do); end
        tick();
        #1;
        checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL pol_after_so got %0b exp 0", net_so); end
        net_polarity = 1'b0;
        cpu_read(2'd3);
        checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL pol_ob_stat got %h exp 0", d_out); end
    endtask

    task automatic test_backpressure();
        net_ro = 1'b0; net_polarity = 1'b0;
        cpu_write(2'd2, 64'h1);
        cpu_write(2'd2, 64'h2);
        cpu_read(2'd2);
        checks++; if (d_out !== 64'h1) begin errors++; $display("FAIL bp_ob_data got %h exp 1", d_out); end
        cpu_read(2'd3);
        checks++; if (d_out !== 64'h1) begin errors++; $display("FAIL bp_ob_stat got %h exp 1", d_out); end
        net_ro = 1'b1;
        #1;
        checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL bp_send_so got %0b exp 1", net_so); end
        checks++; if (net_do !== 64'h1) begin errors++; $display("FAIL bp_send_do got %h exp 1", net_do); end
        tick();
        #1;
        checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL bp_after_so got %0b exp 0", net_so); end
        net_ro = 1'b0;
    endtask

    task automatic test_write_drop_on_send();
        // Load a vc=0 flit, hold it with mismatched polarity, then write while it sends.
        net_ro = 1'b1; net_polarity = 1'b1;
        cpu_write(2'd2, 64'h5);
        net_polarity = 1'b0;
        cpu_write(2'd2, 64'h6);
        net_ro = 1'b0;
        cpu_read(2'd3);
        checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL drop_ob_stat got %h exp 0", d_out); end
        cpu_read(2'd2);
        checks++; if (d_out !== 64'h5) begin errors++; $display("FAIL drop_ob_data got %h exp 5", d_out); end
    endtask

    task automatic test_ejection();
        net_si = 1'b1; net_di = 64'h8020_0000_DEAD_BEEF;
        #1;
        checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL ej_ri_before got %0b exp 1", net_ri); end
        tick();
        net_si = 1'b0;
        #1;
        checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL ej_ri_full got %0b exp 0", net_ri); end
        cpu_read(2'd1);
        checks++; if (d_out !== 64'h1) begin errors++; $display("FAIL ej_ib_stat got %h exp 1", d_out); end
        cpu_read(2'd0);
        checks++; if (d_out !== 64'h8020_0000_DEAD_BEEF) begin errors++; $display("FAIL ej_data got %h exp 80200000deadbeef", d_out); end
        checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL ej_ri_after got %0b exp 1", net_ri); end
        cpu_read(2'd1);
        checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL ej_ib_stat2 got %h exp 0", d_out); end
    endtask

    task automatic test_eject_backpressure();
        net_si = 1'b1; net_di = 64'h8020_0000_DEAD_BEEF;
        tick();
        net_di = 64'h0000_0000_0000_CAFE;
        tick();
        tick();
        checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL ebp_ri_held got %0b exp 0", net_ri); end
        cpu_read(2'd0);
        checks++; if (d_out !== 64'h8020_0000_DEAD_BEEF) begin errors++; $display("FAIL ebp_first got %h exp 80200000deadbeef", d_out); end
        #1;
        checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL ebp_ri_free got %0b exp 1", net_ri); end
        tick();
        net_si = 1'b0;
        #1;
        checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL ebp_ri_cap got %0b exp 0", net_ri); end
        cpu_read(2'd0);
        checks++; if (d_out !== 64'h0000_0000_0000_CAFE) begin errors++; $display("FAIL ebp_second got %h exp cafe", d_out); end
    endtask

    task automatic test_concurrency();
        net_ro = 1'b0; net_polarity = 1'b0;
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'd2; d_in = 64'h8000_0000_0000_0077;
        net_si = 1'b1; net_di = 64'h0000_0000_1111_2222;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0; net_si = 1'b0;
        #1;
        checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL conc_ri got %0b exp 0", net_ri); end
        cpu_read(2'd3);
        checks++; if (d_out !== 64'h1) begin errors++; $display("FAIL conc_ob_stat got %h exp 1", d_out); end
        net_ro = 1'b1; net_polarity = 1'b1;
        #1;
        checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL conc_so got %0b exp 1", net_so); end
        checks++; if (net_do !== 64'h8000_0000_0000_0077) begin errors++; $display("FAIL conc_do got %h exp 8000000000000077", net_do); end
        tick();
        net_ro = 1'b0;
        #1;
        checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL conc_so_after got %0b exp 0", net_so); end
        cpu_read(2'd0);
        checks++; if (d_out !== 64'h0000_0000_1111_2222) begin errors++; $display("FAIL conc_ib_data got %h exp 11112222", d_out); end
    endtask

    task automatic test_read_capture_same_cycle();
        // Buffer empty, ib_data holds 0x11112222: read and capture together.
        nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'd0;
        net_si = 1'b1; net_di = 64'h0000_0000_3333_4444;
        tick();
        nicEn = 1'b0; net_si = 1'b0;
        checks++; if (d_out !== 64'h0000_0000_1111_2222) begin errors++; $display("FAIL rc_old got %h exp 11112222", d_out); end
        #1;
        checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL rc_ri got %0b exp 0", net_ri); end
        cpu_read(2'd0);
        checks++; if (d_out !== 64'h0000_0000_3333_4444) begin errors++; $display("FAIL rc_new got %h exp 33334444", d_out); end
    endtask

    task automatic test_mid_reset();
        net_ro = 1'b0; net_polarity = 1'b0;
        cpu_write(2'd2, 64'h9);
        net_si = 1'b1; net_di = 64'hAB;
        tick();
        cpu_read(2'd1);
        checks++; if (d_out !== 64'h1) begin errors++; $display("FAIL mr_pre_ib got %h exp 1", d_out); end
        net_di = 64'hCD;
        reset = 1'b0;
        tick();
        reset = 1'b1; net_si = 1'b0; net_ro = 1'b1; net_polarity = 1'b0;
        #1;
        checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL mr_ri got %0b exp 1", net_ri); end
        checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL mr_so got %0b exp 0", net_so); end
        checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL mr_d_out got %h exp 0", d_out); end
        net_ro = 1'b0;
        cpu_read(2'd3);
        checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL mr_ob_stat got %h exp 0", d_out); end
        cpu_read(2'd2);
        checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL mr_ob_data got %h exp 0", d_out); end
        cpu_read(2'd1);
        checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL mr_ib_stat got %h exp 0", d_out); end
        cpu_read(2'd0);
        checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL mr_ib_data got %h exp 0", d_out); end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; addr = 2'd0; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_ro = 1'b0; net_polarity = 1'b0; net_si = 1'b0; net_di = '0;
        test_reset();
        test_polarity();
        test_backpressure();
        test_write_drop_on_send();
        test_ejection();
        test_eject_backpressure();
        test_concurrency();
        test_read_capture_same_cycle();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cardinal_nic.md
# cardinal_nic

Network interface controller for one node of the cardinal-router mesh. It couples a processor-side register interface to the router's local (NIC) port. It injects one 64-bit flit per transfer into the router and accepts one flit per transfer from it. Each direction is buffered in a single-entry register. Injection is gated by the router's polarity signal, so a flit enters the network only in a cycle whose polarity matches the flit's VC bit.

## Interface
Parameters:
- DATA_W, 64, flit width; bit 63 is VC, bits 62/61 are Xdir/Ydir, 60:56 reserved, 55:52 hopX, 51:48 hopY, 47:0 payload.
- ADDR_W, 2, processor register address width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  reset, synchronous, active-low.
- addr  in  2  register select: 0 = input buffer, 1 = input status, 2 = output buffer, 3 = output status.
- d_in  in  64  processor write data.
- d_out  out  64  processor read data, registered.
- nicEn  in  1  register access enable.
- nicWrEn  in  1  1 = write, 0 = read; only meaningful with nicEn.
- net_so  out  1  flit valid toward router NIC input.
- net_ro  in  1  router NIC input ready.
- net_do  out  64  flit toward router.
- net_polarity  in  1  router polarity.
- net_si  in  1  flit valid from router NIC output.
- net_ri  out  1  ready toward router NIC output.
- net_di  in  64  flit from router.

## Operation
- State: ob_data[63:0], ob_full, ib_data[63:0], ib_full, d_out register.
- Injection path (processor to router):
  - net_do = ob_data at all times.
  - net_so = ob_full & net_ro & (net_polarity == ob_data[63]). Purely combinational.
  - A transfer occurs in any cycle with net_so = 1. ob_full clears at that edge.
- Processor write to addr 2 (nicEn & nicWrEn):
  - If ob_full = 0 at the edge, the write loads ob_data and sets ob_full.
  - If ob_full = 1 at the edge, the write is dropped. This holds even when a transfer occurs in the same cycle.
- Ejection path (router to processor):
  - net_ri = ~ib_full.
  - If net_si & net_ri, ib_data <= net_di and ib_full <= 1.
- Processor read:
  - addr 0: d_out <= ib_data. Clears ib_full if it was set. If ib_full = 0, returns stale data and changes no state.
  - addr 1: d_out <= {63'b0, ib_full}.
  - addr 3: d_out <= {63'b0, ob_full}.
  - addr 2: d_out <= ob_data; no side effect.
- Writes to addr 0, 1, 3 are ignored.
- When nicEn = 0, d_out holds its value.
- No flit decoding: hop fields and payload pass through unmodified in both directions.
- On reset (reset = 0 at an edge): ob_full = 0, ib_full = 0, ob_data = 0, ib_data = 0, d_out = 0.
  - Outputs after reset: net_so = 0, net_ri = 1.
  - Reset mid-transfer discards both buffers. Any flit presented on that edge is not captured.

## Timing
- Processor write to addr 2 at edge N: ob_full = 1 after N. net_so can assert in cycle N+1 when net_ro = 1 and polarity matches.
- Injection waits cycle by cycle while polarity mismatches or net_ro = 0. net_do stays stable throughout.
- Injection transfer at edge M: net_so = 0 in cycle M+1. Minimum spacing between injected flits is 2 cycles (write, then send).
- Router delivery captured at edge K: net_ri = 0 from cycle K+1 until a processor read of addr 0.
- Read of addr 0 at edge R: d_out valid after R, and net_ri = 1 in cycle R+1. Delivery-to-delivery spacing is at least 2 cycles.
- Read latency is 1 cycle; d_out is registered.
- Simultaneous edge events:
  - An addr 0 read and a router flit cannot both hit a full buffer, because net_ri = 0.
  - With ib_full = 0, an addr 0 read in the same cycle as a capture returns the old ib_data. The new flit is retained with ib_full = 1.

## Test plan
- Reset: hold reset = 0 for 4 cycles → net_so = 0, net_ri = 1, d_out = 0; reads of addr 1 and addr 3 return 0.
- Polarity-gated injection:
  - Write FLIT 0xA000_0000_0000_1234 (vc = 1) to addr 2, with net_ro = 1.
  - Hold net_polarity = 0 for 3 cycles → net_so = 0 throughout.
  - Set polarity to 1 → net_so = 1 for exactly one cycle with net_do = 0xA000_0000_0000_1234; addr 3 then reads 0.
- Backpressure and drop:
  - With net_ro = 0, write 0x0000_0000_0000_0001, then write 0x0000_0000_0000_0002 → second write dropped.
  - Release net_ro with matching polarity → net_do = 0x...0001.
- Ejection:
  - Drive net_si = 1 with 0x8020_0000_DEAD_BEEF → net_ri = 0 next cycle; addr 1 reads 1.
  - Read addr 0 → d_out = 0x8020_0000_DEAD_BEEF, and net_ri returns to 1 the following cycle.
- Ejection backpressure: hold net_si = 1 with a second flit 0x...CAFE while ib_full = 1 → no capture; after the addr 0 read, 0x...CAFE is captured.
- Concurrency: write addr 2 and receive a router flit in the same cycle, then let the send proceed → both paths complete independently with correct data.
- Mid-operation reset: apply reset while both buffers are full → both buffers are cleared.
